// File: rtl/dm_cache_ctrl.sv
// dm_cache_ctrl: direct-mapped, write-through, no-write-allocate cache controller
// with a valid/ready CPU port and a req/ack memory port.
// Optional build macro CACHE_STATS_EN adds saturating hit_count/miss_count outputs.
//
// state    | meaning
// ---------+----------------------------------------------------------
// S_IDLE   | req_ready high, waiting for a CPU request
// S_LOOKUP | tag compare on the captured request; read hits complete here
// S_MEM_RD | line fill: memory read outstanding until mem_ack
// S_MEM_WR | write-through: memory write outstanding until mem_ack
module dm_cache_ctrl #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 12,
  parameter int INDEX_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_hit,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {S_IDLE, S_LOOKUP, S_MEM_RD, S_MEM_WR} state_t;

  state_t r_state, w_state_nxt;

  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_lookup_hit;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];

  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_rdata;
  logic              r_resp_hit;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic               w_hit;
  logic               w_fill;
  logic               w_wr_hit;

  assign w_index  = r_addr[INDEX_W-1:0];
  assign w_tag    = r_addr[ADDR_W-1:INDEX_W];
  assign w_hit    = r_valid[w_index] && (r_tag[w_index] == w_tag);
  assign w_fill   = (r_state == S_MEM_RD) && mem_ack;
  assign w_wr_hit = (r_state == S_LOOKUP) && r_write && w_hit;

  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_hit   = r_resp_hit;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (r_write)    w_state_nxt = S_MEM_WR;
        else if (w_hit) w_state_nxt = S_IDLE;
        else            w_state_nxt = S_MEM_RD;
      end
      S_MEM_RD, S_MEM_WR: if (mem_ack) w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Capture the accepted request and remember the lookup result for write completion.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_write      <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_lookup_hit <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && req_valid) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
      end
      if (r_state == S_LOOKUP) r_lookup_hit <= w_hit;
    end
  end

  // Valid bits: cleared by reset, set by a completed fill.
  always_ff @(posedge clk) begin
    if (!rst)        r_valid <= '0;
    else if (w_fill) r_valid[w_index] <= 1'b1;
  end

  // Tag/data arrays keep their contents across reset; a fill racing reset is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      if (w_fill) begin
        r_tag[w_index]  <= w_tag;
        r_data[w_index] <= mem_rdata;
      end else if (w_wr_hit) begin
        r_data[w_index] <= r_wdata;
      end
    end
  end

  // Response and memory-port registers; mem_* hold steady while mem_req is high.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_hit   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_LOOKUP: begin
          if (!r_write && w_hit) begin
            r_resp_valid <= 1'b1;
            r_resp_rdata <= r_data[w_index];
            r_resp_hit   <= 1'b1;
          end else begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= r_write;
            r_mem_addr  <= r_addr;
            r_mem_wdata <= r_wdata;
          end
        end
        S_MEM_RD: if (mem_ack) begin
          r_mem_req    <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_rdata <= mem_rdata;
          r_resp_hit   <= 1'b0;
        end
        S_MEM_WR: if (mem_ack) begin
          r_mem_req    <= 1'b0;
          r_resp_valid <= 1'b1;
          r_resp_hit   <= r_lookup_hit;
        end
        default: ;
      endcase
    end
  end

`ifdef CACHE_STATS_EN
  logic [31:0] r_hit_count;
  logic [31:0] r_miss_count;

  // One count per lookup, reads and writes alike, saturating at all-ones.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) begin
        if (r_hit_count != 32'hFFFF_FFFF) r_hit_count <= r_hit_count + 32'd1;
      end else begin
        if (r_miss_count != 32'hFFFF_FFFF) r_miss_count <= r_miss_count + 32'd1;
      end
    end
  end

  assign hit_count  = r_hit_count;
  assign miss_count = r_miss_count;
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: transaction-level cache/RAM model, per-cycle output
// compare, directed scenarios with literal expectations, then randomized traffic.
`timescale 1ns/1ps
module tb_dm_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready, resp_valid, resp_hit, mem_req, mem_we;
  logic [31:0] resp_rdata, mem_wdata;
  logic [11:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  dm_cache_ctrl #(.DATA_W(32), .ADDR_W(12), .INDEX_W(6)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: RAM contents plus the architectural cache state.
  logic [31:0] ram [4096];
  bit          mv  [64];
  logic [5:0]  mt  [64];
  logic [31:0] md  [64];
  int unsigned m_hits, m_misses;

  // Per-cycle expectations published by the driver.
  bit          chk_en = 1'b0;
  bit          exp_ready, exp_resp_due, exp_hit, exp_mem_req, exp_mem_we, exp_post_reset;
  logic [11:0] exp_mem_addr;
  logic [31:0] exp_mem_wdata, exp_last_rdata;

  // Observations used by the directed literal checks.
  bit          obs_hit;
  logic [31:0] obs_rdata;
  int          obs_mem_cnt = 0;
  bit          prev_mem_req = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("req_ready", req_ready, exp_ready);
      chk1("resp_valid", resp_valid, exp_resp_due);
      chk32("resp_rdata", resp_rdata, exp_last_rdata);
      if (exp_resp_due) chk1("resp_hit", resp_hit, exp_hit);
      chk1("mem_req", mem_req, exp_mem_req);
      if (exp_mem_req) begin
        chk1("mem_we", mem_we, exp_mem_we);
        chk32("mem_addr", 32'(mem_addr), 32'(exp_mem_addr));
        if (exp_mem_we) chk32("mem_wdata", mem_wdata, exp_mem_wdata);
      end
      if (exp_post_reset) begin
        chk1("rst_resp_hit", resp_hit, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk32("rst_mem_wdata", mem_wdata, 32'h0);
      end
`ifdef CACHE_STATS_EN
      chk32("hit_count", hit_count, m_hits);
      chk32("miss_count", miss_count, m_misses);
`endif
      if (resp_valid) begin
        obs_hit   = resp_hit;
        obs_rdata = resp_rdata;
      end
      if (mem_req && !prev_mem_req) obs_mem_cnt++;
    end
    prev_mem_req = mem_req;
  end

  task automatic post_reset_state();
    for (int i = 0; i < 64; i++) mv[i] = 1'b0;
    exp_ready = 1'b1; exp_resp_due = 1'b0; exp_mem_req = 1'b0;
    exp_post_reset = 1'b1; exp_last_rdata = '0;
    m_hits = 0; m_misses = 0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      mem_ack = 1'($urandom);
      mem_rdata = $urandom;
      exp_ready = 1'b1; exp_resp_due = 1'b0; exp_mem_req = 1'b0; exp_post_reset = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    chk_en = 1'b0; rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    post_reset_state();
    chk_en = 1'b1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // One CPU transaction, with the bench acting as memory. lat = extra mem_req cycles
  // before ack; rst_req asserts reset somewhere inside the memory phase.
  task automatic access(input bit wr, input logic [11:0] addr, input logic [31:0] wd,
                        input int lat, input bit rst_req);
    logic [5:0]  idx, tag;
    logic [31:0] rd;
    bit          hit, memop;
    int          exp_n, n, rst_at;
    idx   = addr[5:0];
    tag   = addr[11:6];
    hit   = mv[idx] && (mt[idx] == tag);
    memop = wr || !hit;
    rd    = (!wr && hit) ? md[idx] : ram[addr];
    exp_n = memop ? 3 + lat : 2;
    rst_at = (rst_req && memop) ? 2 + int'($urandom_range(0, lat)) : 0;

    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    n = 0;
    while (1) begin
      @(posedge clk); #1;
      n++;
      req_valid = (n < exp_n) ? 1'($urandom) : 1'b0;
      req_write = 1'($urandom); req_addr = 12'($urandom); req_wdata = $urandom;
      exp_ready      = (n >= exp_n);
      exp_resp_due   = (n == exp_n);
      exp_post_reset = 1'b0;
      exp_mem_req    = memop && (n >= 2) && (n < exp_n);
      exp_mem_we     = wr;
      exp_mem_addr   = addr;
      exp_mem_wdata  = wd;
      mem_rdata = $urandom;
      if (exp_mem_req) begin
        mem_ack = (n == exp_n - 1);
        if (mem_ack && !wr) mem_rdata = rd;
      end else begin
        mem_ack = 1'($urandom);
      end
      if (n == 2) begin
        if (hit) m_hits++;
        else     m_misses++;
      end
      if (exp_resp_due) begin
        exp_hit = hit;
        if (!wr) exp_last_rdata = rd;
      end
      if (rst_at != 0 && n == rst_at) begin
        rst = 1'b0;
        mem_ack = 1'($urandom);
        @(posedge clk); #1;
        rst = 1'b1; req_valid = 1'b0; mem_ack = 1'b0;
        post_reset_state();
        return;
      end
      if (n == exp_n) break;
    end
    if (wr) begin
      ram[addr] = wd;
      if (hit) md[idx] = wd;
    end else if (!hit) begin
      mv[idx] = 1'b1; mt[idx] = tag; md[idx] = rd;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] a;
    bit          w;
    for (int i = 0; i < 4096; i++) ram[i] = $urandom;
    ram[12'h040] = 32'hDEAD_BEEF;
    for (int i = 0; i < 64; i++) begin mv[i] = 1'b0; mt[i] = '0; md[i] = '0; end
    exp_hit = 1'b0; exp_mem_we = 1'b0; exp_mem_addr = '0; exp_mem_wdata = '0;
    obs_hit = 1'b0; obs_rdata = '0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    post_reset_state();
    chk_en = 1'b1;
    idle(2);

    // Cold read, then re-read hit.
    obs_mem_cnt = 0;
    access(1'b0, 12'h040, 32'h0, 2, 1'b0); settle();
    chk1("tp1_miss_hit", obs_hit, 1'b0);
    chk32("tp1_miss_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk32("tp1_miss_memreqs", 32'(obs_mem_cnt), 32'd1);
    obs_mem_cnt = 0;
    access(1'b0, 12'h040, 32'h0, 0, 1'b0); settle();
    chk1("tp1_hit_hit", obs_hit, 1'b1);
    chk32("tp1_hit_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk32("tp1_hit_memreqs", 32'(obs_mem_cnt), 32'd0);

    // Conflict eviction on index 0.
    access(1'b0, 12'h080, 32'h0, 1, 1'b0); settle();
    chk1("tp2_evict_hit", obs_hit, 1'b0);
    obs_mem_cnt = 0;
    access(1'b0, 12'h040, 32'h0, 0, 1'b0); settle();
    chk1("tp2_refill_hit", obs_hit, 1'b0);
    chk32("tp2_refill_rdata", obs_rdata, 32'hDEAD_BEEF);
    chk32("tp2_refill_memreqs", 32'(obs_mem_cnt), 32'd1);

    // Write hit, write-through, then read back.
    obs_mem_cnt = 0;
    access(1'b1, 12'h040, 32'h1234_5678, 1, 1'b0); settle();
    chk1("tp3_write_hit", obs_hit, 1'b1);
    chk32("tp3_write_memreqs", 32'(obs_mem_cnt), 32'd1);
    access(1'b0, 12'h040, 32'h0, 0, 1'b0); settle();
    chk1("tp3_read_hit", obs_hit, 1'b1);
    chk32("tp3_read_rdata", obs_rdata, 32'h1234_5678);

    // Write miss does not allocate.
    access(1'b1, 12'h3C5, 32'hA5A5_A5A5, 0, 1'b0); settle();
    chk1("tp4_write_hit", obs_hit, 1'b0);
    access(1'b0, 12'h3C5, 32'h0, 1, 1'b0); settle();
    chk1("tp4_read_hit", obs_hit, 1'b0);
    chk32("tp4_read_rdata", obs_rdata, 32'hA5A5_A5A5);

    // Reset during a pending fill.
    access(1'b0, 12'h100, 32'h0, 20, 1'b1);
    idle(3);
    access(1'b0, 12'h100, 32'h0, 0, 1'b0); settle();
    chk1("tp5_same_addr_hit", obs_hit, 1'b0);
    access(1'b0, 12'h040, 32'h0, 0, 1'b0); settle();
    chk1("tp5_cleared_hit", obs_hit, 1'b0);

`ifdef CACHE_STATS_EN
    do_reset();
    access(1'b0, 12'h001, 32'h0, 0, 1'b0);
    access(1'b0, 12'h001, 32'h0, 0, 1'b0);
    access(1'b0, 12'h001, 32'h0, 0, 1'b0);
    access(1'b0, 12'h002, 32'h0, 1, 1'b0);
    access(1'b0, 12'h002, 32'h0, 0, 1'b0);
    settle();
    chk32("tp6_hit_count", hit_count, 32'd3);
    chk32("tp6_miss_count", miss_count, 32'd2);
    do_reset();
    settle();
    chk32("tp6_rst_hit_count", hit_count, 32'd0);
    chk32("tp6_rst_miss_count", miss_count, 32'd0);
`endif

    // Randomized traffic over a small address pool to force hits and conflicts.
    for (int t = 0; t < 400; t++) begin
      w = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) begin
        a = 12'($urandom);
      end else begin
        a[11:6] = 6'($urandom_range(0, 3));
        a[5:0]  = 6'($urandom_range(0, 7));
      end
      access(w, a, $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 49) == 0));
      if ($urandom_range(0, 5) == 0) idle(int'($urandom_range(1, 2)));
    end

    idle(2);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
